hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns every HI/LO write originating in EX. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a shared 32-iteration shift/add-subtract datapath for mul/div. It holds the pipeline via stallreq while iterating, then presents results on the EX-stage HI/LO write port (ex_hi_we/ex_lo_we/ex_hi_in/ex_lo_in of the HI/LO register file).

Parameters:
WIDTH, 32, operand width; fixed at 32 for this core.
CNT_W, 6, iteration counter width; must hold 0..WIDTH.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
op_valid  in  1  EX holds a valid HI/LO-class instruction
op_code  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved (no-op)
src_a  in  32  rs operand (multiplicand/dividend/MTHI/MTLO data)
src_b  in  32  rt operand (multiplier/divisor)
flush  in  1  cancel current operation (exception/redirect)
ex_stall  in  1  EX stage held by stall controller this cycle (stall[2])
stallreq  out  1  request to stall IF..EX
busy  out  1  state != IDLE
hi_we  out  1  HI write enable to EX/MEM and HI/LO forwarding
lo_we  out  1  LO write enable
hi_out  out  32  HI write data
lo_out  out  32  LO write data

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, datapath regs 0; stallreq, busy, hi_we, lo_we = 0; hi_out, lo_out = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - op_valid & MTHI: hi_we=1, hi_out=src_a, same cycle, combinational; no stall.
  - op_valid & MTLO: lo_we=1, lo_out=src_a, same cycle; no stall.
  - op_valid & mul/div (cycle T): stallreq=1 combinationally; latch |src_a|, |src_b| (abs only for signed ops), result signs, op kind; counter=0; next RUN.
  - Reserved codes: no outputs, stay IDLE.
- RUN (T+1..T+32): one iteration per cycle; stallreq=1; counter increments. On counter==31 -> DONE.
  - Mul: radix-2 shift-add, 64-bit product.
  - Div: radix-2 restoring, 32-bit quotient and remainder.
- DONE (T+33, held while ex_stall=1): stallreq=0, hi_we=lo_we=1.
  - Mul: {hi_out, lo_out} = product, negated (two's complement, 64-bit) for MULT when operand signs differ.
  - Div: lo_out = quotient, negated for DIV when signs differ; hi_out = remainder, takes dividend sign for DIV.
  - Exits to IDLE on the first edge with ex_stall=0; op_valid is ignored in DONE (prevents a re-issue of the held instruction).
- Latency: mul/div results visible 33 cycles after acceptance; stallreq high for exactly 33 cycles (T..T+32).
- Divide by zero: latency unchanged; hi_out=src_a as latched (original signed value), lo_out=32'hFFFFFFFF, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0 (magnitude arithmetic wraps naturally).
- flush=1 (sync, highest priority after reset): forces stallreq, hi_we, lo_we = 0 in that cycle, including the MTHI/MTLO pass-through. Next edge -> IDLE with counter cleared; the operation is discarded, no HI/LO write.
- stallreq never asserted in DONE or IDLE except at the acceptance cycle.

Decomposition:
- defines.vh: op_code constants (`MD_MULT .. `MD_MTLO).
- State encodings stay local to the module.
- One sub-module: md_iter_core contains the 64-bit shift register, 33-bit adder/subtractor, and per-iteration step for mul or div. The controller owns the FSM, counter, sign handling and output muxing.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3 -> stallreq high T..T+32; T+33 hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA, hi_we=lo_we=1.
- MULTU same operands -> hi_out=0x00000002, lo_out=0xFFFFFFFA at T+33.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. DIVU 7/2 -> lo_out=3, hi_out=1.
- DIVU src_a=0x12345678, src_b=0 -> at T+33 hi_out=0x12345678, lo_out=0xFFFFFFFF. MTHI src_a=0xA5A5A5A5 in IDLE -> hi_we=1, hi_out=0xA5A5A5A5 same cycle, stallreq=0.
- DIV started, flush=1 at T+10 -> stallreq=0 that cycle, IDLE at T+11, no hi_we/lo_we ever. Back-to-back DIV then accepts normally at T+11.
- MULT reaches DONE with ex_stall=1 for 3 cycles -> hi_we/lo_we and data held 4 cycles, no restart. IDLE after ex_stall drops; next op_valid MULT restarts exactly once.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared constants and HI/LO operation codes for the multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

endpackage

// File: rtl/hilo_muldiv_ctrl_md_iter_core.sv
// Shared radix-2 iteration datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per cycle.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  // Mul: acc = {partial product, multiplier}, shifts right.
  // Div: acc = {partial remainder, dividend/quotient}, shifts left.
  assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    if (load_i) begin
      div_d  = is_div_i;
      acc_d  = {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
      opnd_d = is_div_i ? b_i : a_i;
    end else if (step_i) begin
      if (div_q) begin
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
        else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write owner for EX: MTHI/MTLO pass-through plus a 32-iteration
// multiply/divide sequencer that stalls the pipeline while it runs.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             stallreq,
  output logic             busy,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               bz_q, bz_d;
  logic [WIDTH-1:0]   araw_q, araw_d;

  logic               load, step, op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
  logic [2*WIDTH-1:0] acc, mul_res;

  assign op_signed = ~op_code[0];
  assign a_mag     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  assign quot      = acc[WIDTH-1:0];
  assign rem       = acc[2*WIDTH-1:WIDTH];
  assign mul_res   = neg_q ? -acc : acc;
  assign busy      = (state_q != S_IDLE);

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (load),
    .step_i   (step),
    .is_div_i (op_code[1]),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .acc_o    (acc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    araw_d   = araw_q;
    load     = 1'b0;
    step     = 1'b0;
    stallreq = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_out   = '0;
    lo_out   = '0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            case (op_code)
              MD_MTHI: begin
                hi_we  = 1'b1;
                hi_out = src_a;
              end
              MD_MTLO: begin
                lo_we  = 1'b1;
                lo_out = src_a;
              end
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                stallreq = 1'b1;
                load     = 1'b1;
                cnt_d    = '0;
                state_d  = S_RUN;
                div_d    = op_code[1];
                neg_d    = op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                rneg_d   = op_signed & src_a[WIDTH-1];
                bz_d     = (src_b == '0);
                araw_d   = src_a;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          stallreq = 1'b1;
          step     = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_DONE;
        end
        S_DONE: begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          if (!div_q) begin
            {hi_out, lo_out} = mul_res;
          end else if (bz_q) begin
            hi_out = araw_q;
            lo_out = '1;
          end else begin
            lo_out = neg_q  ? -quot : quot;
            hi_out = rneg_q ? -rem  : rem;
          end
          // op_valid is deliberately not looked at here: EX still holds the same instruction.
          if (!ex_stall) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      araw_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      araw_q  <= araw_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench: drivers push expected HI/LO writes from an arithmetic model,
// a negedge monitor pops and compares every write the DUT presents.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        flush, ex_stall;
  logic        stallreq, busy, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;

  typedef struct packed {
    logic        hwe;
    logic        lwe;
    logic [31:0] hi;
    logic [31:0] lo;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;

  hilo_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .ex_stall (ex_stall),
    .stallreq (stallreq),
    .busy     (busy),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {63'b0, act}, {63'b0, exp});
  endtask

  // MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic wr_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    wr_t         r;
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    r     = '0;
    r.hwe = 1'b1;
    r.lwe = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      3'd1: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = 32'hFFFF_FFFF;
        end else if (op == 3'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          p = sq; r.lo = p[31:0];
          p = sr; r.hi = p[31:0];
        end else begin
          p = ua / ub; r.lo = p[31:0];
          p = ua % ub; r.hi = p[31:0];
        end
      end
      3'd4: begin r.lwe = 1'b0; r.hi = a; end
      3'd5: begin r.hwe = 1'b0; r.lo = a; end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst && (hi_we || lo_we)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got hi_we=%b lo_we=%b hi=%h lo=%h, required no write",
                   hi_we, lo_we, hi_out, lo_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_en", {62'b0, hi_we, lo_we}, {62'b0, mon_e.hwe, mon_e.lwe});
          if (mon_e.hwe) chk("hi_out", {32'b0, hi_out}, {32'b0, mon_e.hi});
          if (mon_e.lwe) chk("lo_out", {32'b0, lo_out}, {32'b0, mon_e.lo});
        end
      end
    end
  end

  // Entered and left at posedge+1; nstall = extra DONE cycles held by ex_stall.
  task automatic issue_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int nstall);
    wr_t e;
    e = model(op, a, b);
    for (int i = 0; i <= nstall; i++) exp_q.push_back(e);
    op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      chk1("stallreq_busy_window", stallreq, 1'b1);
      @(posedge clk); #1;
      if (k == 0) begin
        op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
      end
    end
    ex_stall = (nstall > 0);
    if (nstall > 0) begin
      op_valid = 1'b1; op_code = op;
    end
    for (int j = 0; j <= nstall; j++) begin
      @(negedge clk);
      chk1("stallreq_done", stallreq, 1'b0);
      chk1("busy_done", busy, 1'b1);
      @(posedge clk); #1;
      if (j == nstall - 1) ex_stall = 1'b0;
    end
    op_valid = 1'b0;
    ex_stall = 1'b0;
    chk1("idle_after_done", busy, 1'b0);
  endtask

  task automatic issue_mt(input logic [2:0] op, input logic [31:0] a, input logic do_flush);
    op_valid = 1'b1; op_code = op; src_a = a; src_b = $urandom;
    flush = do_flush;
    if (!do_flush) exp_q.push_back(model(op, a, 32'h0));
    @(negedge clk);
    chk1("mt_stallreq", stallreq, 1'b0);
    chk1("mt_busy", busy, 1'b0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic issue_rsv(input logic [2:0] op);
    op_valid = 1'b1; op_code = op; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    chk1("rsv_stallreq", stallreq, 1'b0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk1("rsv_busy", busy, 1'b0);
  endtask

  task automatic issue_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int at);
    op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
    for (int k = 0; k < at; k++) begin
      @(negedge clk);
      chk1("flush_pre_stallreq", stallreq, 1'b1);
      @(posedge clk); #1;
      if (k == 0) op_valid = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    chk1("flush_stallreq", stallreq, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    chk1("flush_idle", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    rst = 1'b0; op_valid = 1'b0; op_code = '0; src_a = '0; src_b = '0;
    flush = 1'b0; ex_stall = 1'b0;
    #1;
    chk("reset_outputs", {28'b0, stallreq, busy, hi_we, lo_we, hi_out}, 64'h0);
    chk("reset_lo", {32'b0, lo_out}, 64'h0);
    #11 rst = 1'b1;
    @(posedge clk); #1;

    issue_md(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    issue_md(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    issue_md(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    issue_md(3'd3, 32'd7, 32'd2, 0);
    issue_md(3'd3, 32'h1234_5678, 32'd0, 0);
    issue_md(3'd2, 32'h8765_4321, 32'd0, 0);
    issue_mt(3'd4, 32'hA5A5_A5A5, 1'b0);
    issue_mt(3'd5, 32'h5A5A_5A5A, 1'b0);
    issue_mt(3'd4, 32'hDEAD_BEEF, 1'b1);
    issue_flush(3'd2, 32'hFFFF_FFF9, 32'd2, 10);
    issue_md(3'd2, 32'd100, 32'hFFFF_FFFD, 0);
    issue_md(3'd0, 32'h8000_0000, 32'h7FFF_FFFF, 3);
    issue_md(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue_flush(3'd0, 32'd5, 32'd6, 33);
    issue_rsv(3'd6);
    issue_rsv(3'd7);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op >= 3'd6)              issue_rsv(op);
      else if (op >= 3'd4)         issue_mt(op, rnd32(), ($urandom_range(0, 7) == 0));
      else if ($urandom_range(0, 7) == 0)
                                   issue_flush(op, rnd32(), rnd32(), int'($urandom_range(1, 33)));
      else                         issue_md(op, rnd32(), rnd32(), int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
